// File: rtl/mnist_seg_frame_ctl.sv
// Frame-synchronous gate and parameter shadowing in front of the MNIST segmentation core.
// Whole frames are passed or dropped at SOF; shadow parameters go active only at a frame boundary.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_DROP | beats are consumed upstream and hidden from the MNIST core
// ST_PASS | beats are forwarded to the MNIST core with its backpressure
module mnist_seg_frame_ctl #(
  parameter int          WB_ADR_WIDTH    = 8,
  parameter int          WB_DAT_WIDTH    = 32,
  parameter int          WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
  parameter int          TUSER_WIDTH     = 1,
  parameter logic        INIT_CTL_RUN    = 1'b0,
  parameter logic [7:0]  INIT_PARAM_TH   = 8'd127,
  parameter logic        INIT_PARAM_INV  = 1'b0,
  parameter logic [2:0]  INIT_COLOR_MODE = 3'b111,
  parameter logic [3:0]  INIT_COLOR_TH   = 4'd1
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tlast,
  input  logic                    s_axi4s_tvalid,
  output logic                    s_axi4s_tready,
  output logic                    m_axi4s_tvalid,
  input  logic                    m_axi4s_tready,
  output logic [7:0]              param_th,
  output logic                    param_inv,
  output logic [2:0]              param_color_mode,
  output logic [3:0]              param_color_th,
  output logic [31:0]             frame_count
);

  localparam logic [31:0] ID_VALUE = 32'h4D53_4643;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_ID       = WB_ADR_WIDTH'('h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL      = WB_ADR_WIDTH'('h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS   = WB_ADR_WIDTH'('h02);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FCOUNT   = WB_ADR_WIDTH'('h03);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_TH    = WB_ADR_WIDTH'('h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_INV   = WB_ADR_WIDTH'('h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_CMODE = WB_ADR_WIDTH'('h0A);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_CTH   = WB_ADR_WIDTH'('h0B);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_AC_TH    = WB_ADR_WIDTH'('h18);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_AC_INV   = WB_ADR_WIDTH'('h19);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_AC_CMODE = WB_ADR_WIDTH'('h1A);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_AC_CTH   = WB_ADR_WIDTH'('h1B);

  typedef enum logic {
    ST_DROP = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic       run_q;
  logic       oneshot_q;
  logic       upd_req_q;
  logic [7:0] sh_th;
  logic       sh_inv;
  logic [2:0] sh_cmode;
  logic [3:0] sh_cth;

  logic       wr_b0;
  logic [7:0] wd;
  logic       wr_ctl;
  logic       sof;
  logic       start;
  logic       pass_sel;
  logic       sof_acc;
  logic       fc_inc;
  logic       os_clr;
  logic       copy;
  logic [WB_DAT_WIDTH-1:0] rd_data;
  logic       unused_bits;

  // Every field lives in byte 0, so only sel[0] can enable a write.
  assign wr_b0  = s_wb_stb_i & s_wb_we_i & s_wb_sel_i[0];
  assign wd     = s_wb_dat_i[7:0];
  assign wr_ctl = wr_b0 & (s_wb_adr_i == ADR_CTL);

  assign s_wb_ack_o = s_wb_stb_i;

  // Stream gate
  assign sof            = s_axi4s_tvalid & s_axi4s_tuser[0];
  assign start          = run_q | oneshot_q;
  assign pass_sel       = sof ? start : (state_q == ST_PASS);
  assign m_axi4s_tvalid = s_axi4s_tvalid & pass_sel;
  assign s_axi4s_tready = pass_sel ? m_axi4s_tready : 1'b1;
  assign sof_acc        = sof & s_axi4s_tready;

  assign copy = (sof_acc & upd_req_q) | (wr_ctl & wd[3]);

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_DROP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fc_inc  = 1'b0;
    os_clr  = 1'b0;
    if (sof_acc) begin
      if (start) begin
        state_d = ST_PASS;
        fc_inc  = 1'b1;
        os_clr  = 1'b1;
      end else begin
        state_d = ST_DROP;
      end
    end
  end

  // A software set in the same cycle as a hardware clear wins.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      run_q     <= INIT_CTL_RUN;
      oneshot_q <= 1'b0;
      upd_req_q <= 1'b0;
    end else begin
      if (wr_ctl) begin
        run_q <= wd[1];
      end
      if (wr_ctl && wd[2]) begin
        oneshot_q <= 1'b1;
      end else if (os_clr) begin
        oneshot_q <= 1'b0;
      end
      if (wr_ctl && wd[0]) begin
        upd_req_q <= 1'b1;
      end else if (sof_acc && upd_req_q) begin
        upd_req_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      sh_th    <= INIT_PARAM_TH;
      sh_inv   <= INIT_PARAM_INV;
      sh_cmode <= INIT_COLOR_MODE;
      sh_cth   <= INIT_COLOR_TH;
    end else if (wr_b0) begin
      if (s_wb_adr_i == ADR_SH_TH)    sh_th    <= wd;
      if (s_wb_adr_i == ADR_SH_INV)   sh_inv   <= wd[0];
      if (s_wb_adr_i == ADR_SH_CMODE) sh_cmode <= wd[2:0];
      if (s_wb_adr_i == ADR_SH_CTH)   sh_cth   <= wd[3:0];
    end
  end

  // Copy samples the registered shadows, so a same-cycle shadow write lands next frame.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      param_th         <= INIT_PARAM_TH;
      param_inv        <= INIT_PARAM_INV;
      param_color_mode <= INIT_COLOR_MODE;
      param_color_th   <= INIT_COLOR_TH;
    end else if (copy) begin
      param_th         <= sh_th;
      param_inv        <= sh_inv;
      param_color_mode <= sh_cmode;
      param_color_th   <= sh_cth;
    end
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      frame_count <= 32'd0;
    end else if (fc_inc) begin
      frame_count <= frame_count + 32'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (s_wb_adr_i)
      ADR_ID:       rd_data = WB_DAT_WIDTH'(ID_VALUE);
      ADR_CTL:      rd_data = WB_DAT_WIDTH'({oneshot_q, run_q, upd_req_q});
      ADR_STATUS:   rd_data = WB_DAT_WIDTH'({oneshot_q, upd_req_q, (state_q == ST_PASS)});
      ADR_FCOUNT:   rd_data = WB_DAT_WIDTH'(frame_count);
      ADR_SH_TH:    rd_data = WB_DAT_WIDTH'(sh_th);
      ADR_SH_INV:   rd_data = WB_DAT_WIDTH'(sh_inv);
      ADR_SH_CMODE: rd_data = WB_DAT_WIDTH'(sh_cmode);
      ADR_SH_CTH:   rd_data = WB_DAT_WIDTH'(sh_cth);
      ADR_AC_TH:    rd_data = WB_DAT_WIDTH'(param_th);
      ADR_AC_INV:   rd_data = WB_DAT_WIDTH'(param_inv);
      ADR_AC_CMODE: rd_data = WB_DAT_WIDTH'(param_color_mode);
      ADR_AC_CTH:   rd_data = WB_DAT_WIDTH'(param_color_th);
      default:      rd_data = '0;
    endcase
  end

  // Read bus is forced to zero while held in reset.
  assign s_wb_dat_o = wb_rst_i ? rd_data : '0;

  assign unused_bits = ^{s_wb_dat_i, s_wb_sel_i, s_axi4s_tuser, s_axi4s_tlast};

endmodule

// File: tb/tb_mnist_seg_frame_ctl.sv
// Directed bench for mnist_seg_frame_ctl: frame gating, one-shot, parameter shadowing,
// backpressure and mid-frame reset, with 64-beat frames standing in for full video frames.
module tb_mnist_seg_frame_ctl;

  localparam int N = 64;

  logic        clk;
  logic        wb_rst_i;
  logic [7:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic [0:0]  tuser;
  logic        tlast;
  logic        tvalid;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  p_th;
  logic        p_inv;
  logic [2:0]  p_cmode;
  logic [3:0]  p_cth;
  logic [31:0] fcount;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  mnist_seg_frame_ctl dut (
    .clk              (clk),
    .wb_rst_i         (wb_rst_i),
    .s_wb_adr_i       (adr),
    .s_wb_dat_i       (dat_w),
    .s_wb_dat_o       (dat_r),
    .s_wb_we_i        (we),
    .s_wb_sel_i       (sel),
    .s_wb_stb_i       (stb),
    .s_wb_ack_o       (ack),
    .s_axi4s_tuser    (tuser),
    .s_axi4s_tlast    (tlast),
    .s_axi4s_tvalid   (tvalid),
    .s_axi4s_tready   (s_tready),
    .m_axi4s_tvalid   (m_tvalid),
    .m_axi4s_tready   (m_tready),
    .param_th         (p_th),
    .param_inv        (p_inv),
    .param_color_mode (p_cmode),
    .param_color_th   (p_cth),
    .frame_count      (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    adr = a; dat_w = d; we = 1'b1; sel = 4'hF; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output logic k);
    adr = a; we = 1'b0; stb = 1'b1;
    #1;
    d = dat_r; k = ack;
    stb = 1'b0;
  endtask

  // One beat per loop pass; optional WB write on the first cycle of beat wr_at.
  task automatic send_frame(input int nbeats, input bit with_sof, input bit rnd,
                            input int wr_at, input logic [7:0] wadr, input logic [31:0] wdat,
                            output int passed, output int mv, output int nrdy);
    passed = 0; mv = 0; nrdy = 0;
    for (int i = 0; i < nbeats; i++) begin
      bit acc;
      int cyc;
      acc = 1'b0; cyc = 0;
      while (!acc && cyc < 64) begin
        tvalid = 1'b1;
        tuser  = (with_sof && i == 0) ? 1'b1 : 1'b0;
        tlast  = (i == nbeats - 1);
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i == wr_at && cyc == 0) begin
          adr = wadr; dat_w = wdat; we = 1'b1; sel = 4'hF; stb = 1'b1;
        end
        #1;
        if (m_tvalid) mv++;
        if (!s_tready) nrdy++;
        if (m_tvalid && m_tready) passed++;
        acc = s_tready;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        cyc++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL beat_timeout beat %0d not accepted within %0d cycles", i, cyc);
        break;
      end
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; m_tready = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic k;
    int p, mv, nr;
    checks++;
    if (dat_r !== 32'h0) begin errors++; $display("FAIL rst_dat_o got %h exp 00000000", dat_r); end
    checks++;
    if ({p_th, p_inv, p_cmode, p_cth} !== {8'd127, 1'b0, 3'b111, 4'd1}) begin
      errors++; $display("FAIL rst_params got %h/%b/%b/%h exp 7f/0/111/1", p_th, p_inv, p_cmode, p_cth);
    end
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_read(8'h00, d, k);
    checks++;
    if (d !== 32'h4D534643) begin errors++; $display("FAIL id got %h exp 4d534643", d); end
    checks++;
    if (k !== 1'b1) begin errors++; $display("FAIL ack got %b exp 1", k); end
    wb_read(8'h18, d, k);
    checks++;
    if (d !== 32'd127) begin errors++; $display("FAIL act_th_rd got %0d exp 127", d); end
    wb_write(8'h05, 32'hFFFF_FFFF);
    wb_read(8'h05, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", d); end
    send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    checks++;
    if (mv !== 0) begin errors++; $display("FAIL stopped_mvalid got %0d cycles exp 0", mv); end
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL stopped_sready_low got %0d cycles exp 0", nr); end
    checks++;
    if (fcount !== 32'd0) begin errors++; $display("FAIL stopped_fcount got %0d exp 0", fcount); end
  endtask

  task automatic test_run_midframe();
    int p, mv, nr;
    send_frame(N, 1'b1, 1'b0, 5, 8'h01, 32'h2, p, mv, nr);
    checks++;
    if (p !== 0) begin errors++; $display("FAIL run_mid_cur_frame passed %0d exp 0", p); end
    for (int f = 0; f < 3; f++) begin
      send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
      exp_fc++;
      checks++;
      if (p !== N) begin errors++; $display("FAIL run_frame%0d passed %0d exp %0d", f, p, N); end
    end
    checks++;
    if (fcount !== 32'(exp_fc)) begin errors++; $display("FAIL run_fcount got %0d exp %0d", fcount, exp_fc); end
    wb_write(8'h01, 32'h0);
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic k;
    int p, mv, nr;
    int exp_p[3];
    exp_p = '{N, 0, 0};
    wb_write(8'h01, 32'h4);
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL os_status_armed got %h exp 5", d); end
    for (int f = 0; f < 3; f++) begin
      send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
      checks++;
      if (p !== exp_p[f]) begin errors++; $display("FAIL os_frame%0d passed %0d exp %0d", f, p, exp_p[f]); end
      if (f == 0) begin
        wb_read(8'h02, d, k);
        checks++;
        if (d[2] !== 1'b0) begin errors++; $display("FAIL os_bit_clear got %b exp 0", d[2]); end
      end
    end
    exp_fc++;
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL os_status_end got %h exp 0", d); end
    checks++;
    if (fcount !== 32'(exp_fc)) begin errors++; $display("FAIL os_fcount got %0d exp %0d", fcount, exp_fc); end
  endtask

  task automatic test_param_update();
    logic [31:0] d; logic k;
    int p, mv, nr;
    wb_write(8'h08, 32'h40);
    send_frame(N, 1'b1, 1'b0, 3, 8'h01, 32'h1, p, mv, nr);
    checks++;
    if (p_th !== 8'd127) begin errors++; $display("FAIL upd_hold_th got %h exp 7f", p_th); end
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL upd_pending got %h exp 2", d); end
    send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    checks++;
    if (p_th !== 8'h40) begin errors++; $display("FAIL upd_applied_th got %h exp 40", p_th); end
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL upd_cleared got %h exp 0", d); end
    wb_read(8'h18, d, k);
    checks++;
    if (d !== 32'h40) begin errors++; $display("FAIL upd_act_rd got %h exp 40", d); end
    // upd_now copies on the write cycle with no stream activity
    wb_write(8'h09, 32'h1);
    wb_write(8'h0A, 32'h5);
    checks++;
    if (p_inv !== 1'b0) begin errors++; $display("FAIL now_before_inv got %b exp 0", p_inv); end
    wb_write(8'h01, 32'h8);
    checks++;
    if ({p_inv, p_cmode} !== {1'b1, 3'b101}) begin
      errors++; $display("FAIL now_applied got %b/%b exp 1/101", p_inv, p_cmode);
    end
    wb_read(8'h01, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL now_ctl_rd got %h exp 0", d); end
    // re-arming upd_req on the very SOF that consumes it keeps it set
    wb_write(8'h08, 32'h55);
    wb_write(8'h01, 32'h1);
    send_frame(N, 1'b1, 1'b0, 0, 8'h01, 32'h1, p, mv, nr);
    checks++;
    if (p_th !== 8'h55) begin errors++; $display("FAIL race_th got %h exp 55", p_th); end
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL race_upd_kept got %h exp 2", d); end
    // shadow write on the copy cycle: copy takes old shadow 0x55
    send_frame(N, 1'b1, 1'b0, 0, 8'h08, 32'h66, p, mv, nr);
    checks++;
    if (p_th !== 8'h55) begin errors++; $display("FAIL race_shadow got %h exp 55", p_th); end
    wb_read(8'h02, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL race_upd_done got %h exp 0", d); end
  endtask

  task automatic test_backpressure_stop();
    logic [31:0] d; logic k;
    int p, mv, nr;
    wb_write(8'h01, 32'h2);
    send_frame(N, 1'b1, 1'b1, -1, 8'h00, 32'h0, p, mv, nr);
    exp_fc++;
    checks++;
    if (p !== N) begin errors++; $display("FAIL bp_frame passed %0d exp %0d", p, N); end
    send_frame(N, 1'b1, 1'b1, 10, 8'h01, 32'h0, p, mv, nr);
    exp_fc++;
    checks++;
    if (p !== N) begin errors++; $display("FAIL bp_stop_cur passed %0d exp %0d", p, N); end
    send_frame(N, 1'b1, 1'b1, -1, 8'h00, 32'h0, p, mv, nr);
    checks++;
    if (p !== 0 || nr !== 0) begin errors++; $display("FAIL bp_stop_next passed %0d stalls %0d exp 0 0", p, nr); end
    checks++;
    if (fcount !== 32'(exp_fc)) begin errors++; $display("FAIL bp_fcount got %0d exp %0d", fcount, exp_fc); end
    // SOF held under ready=0
    wb_write(8'h01, 32'h2);
    tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, s_tready} !== 2'b10) begin
      errors++; $display("FAIL hold_handshake got mv=%b sr=%b exp 1 0", m_tvalid, s_tready);
    end
    checks++;
    if (fcount !== 32'(exp_fc)) begin errors++; $display("FAIL hold_fcount got %0d exp %0d", fcount, exp_fc); end
    wb_read(8'h02, d, k);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL hold_state got %b exp 0", d[0]); end
    m_tready = 1'b1;
    @(posedge clk); #1;
    tuser = 1'b0;
    exp_fc++;
    checks++;
    if (fcount !== 32'(exp_fc)) begin errors++; $display("FAIL release_fcount got %0d exp %0d", fcount, exp_fc); end
    send_frame(N - 1, 1'b0, 1'b1, -1, 8'h00, 32'h0, p, mv, nr);
    checks++;
    if (p !== N - 1) begin errors++; $display("FAIL release_rest passed %0d exp %0d", p, N - 1); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic k;
    int p, mv, nr;
    wb_write(8'h01, 32'h2);
    send_frame(20, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    exp_fc++;
    checks++;
    if (p !== 20 || fcount !== 32'(exp_fc)) begin
      errors++; $display("FAIL pre_rst passed %0d fcount %0d exp 20 %0d", p, fcount, exp_fc);
    end
    tvalid = 1'b1; tuser = 1'b0; adr = 8'h00; stb = 1'b1;
    wb_rst_i = 1'b0;
    #1;
    checks++;
    if ({p_th, p_inv, p_cmode, p_cth} !== {8'd127, 1'b0, 3'b111, 4'd1}) begin
      errors++; $display("FAIL midrst_params got %h/%b/%b/%h exp 7f/0/111/1", p_th, p_inv, p_cmode, p_cth);
    end
    checks++;
    if (fcount !== 32'd0) begin errors++; $display("FAIL midrst_fcount got %0d exp 0", fcount); end
    checks++;
    if ({m_tvalid, s_tready} !== 2'b01) begin
      errors++; $display("FAIL midrst_gate got mv=%b sr=%b exp 0 1", m_tvalid, s_tready);
    end
    checks++;
    if (dat_r !== 32'h0) begin errors++; $display("FAIL midrst_dat_o got %h exp 0", dat_r); end
    stb = 1'b0;
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    exp_fc = 0;
    send_frame(N - 20, 1'b0, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    checks++;
    if (p !== 0) begin errors++; $display("FAIL postrst_rest passed %0d exp 0", p); end
    wb_read(8'h01, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL postrst_ctl got %h exp 0", d); end
    wb_write(8'h01, 32'h2);
    send_frame(N, 1'b1, 1'b0, -1, 8'h00, 32'h0, p, mv, nr);
    exp_fc++;
    checks++;
    if (p !== N || fcount !== 32'(exp_fc)) begin
      errors++; $display("FAIL postrst_frame passed %0d fcount %0d exp %0d %0d", p, fcount, N, exp_fc);
    end
  endtask

  initial begin
    wb_rst_i = 1'b0;
    adr = 8'h00; dat_w = 32'h0; we = 1'b0; sel = 4'h0; stb = 1'b0;
    tuser = 1'b0; tlast = 1'b0; tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_run_midframe();
    test_oneshot();
    test_param_update();
    test_backpressure_stop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_seg_frame_ctl.md
Name: mnist_seg_frame_ctl

Overview:
Frame-synchronous controller in front of video_mnist_seg / video_mnist_seg_color. Holds Wishbone-programmable shadow parameters and transfers them to the active outputs only on a frame boundary. Gates the AXI4-Stream control handshake so that whole frames are either passed to the MNIST segmentation core or dropped (run / one-shot / stop). Counts passed frames for software.

Parameters:
WB_ADR_WIDTH, 8, Wishbone word-address width
WB_DAT_WIDTH, 32, Wishbone data width
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
TUSER_WIDTH, 1, AXI4S tuser width; bit0 is start-of-frame (SOF)
INIT_CTL_RUN, 1'b0, reset value of CONTROL.run
INIT_PARAM_TH, 127, reset binarize threshold
INIT_PARAM_INV, 1'b0, reset invert flag
INIT_COLOR_MODE, 3'b111, reset color mode
INIT_COLOR_TH, 1, reset color count threshold (4 bits)

Ports:
clk  in  1  clock (stream and Wishbone share it)
wb_rst_i  in  1  reset, asynchronous, active-low
s_wb_adr_i  in  WB_ADR_WIDTH  word address
s_wb_dat_i  in  WB_DAT_WIDTH  write data
s_wb_dat_o  out  WB_DAT_WIDTH  read data
s_wb_we_i  in  1  write enable
s_wb_sel_i  in  WB_SEL_WIDTH  byte select
s_wb_stb_i  in  1  strobe
s_wb_ack_o  out  1  acknowledge
s_axi4s_tuser  in  TUSER_WIDTH  upstream tuser
s_axi4s_tlast  in  1  upstream tlast
s_axi4s_tvalid  in  1  upstream valid
s_axi4s_tready  out  1  upstream ready
m_axi4s_tvalid  out  1  valid to MNIST core (tuser/tlast/tdata wired around this block)
m_axi4s_tready  in  1  ready from MNIST core
param_th  out  8  active threshold
param_inv  out  1  active invert
param_color_mode  out  3  active color mode
param_color_th  out  4  active color threshold
frame_count  out  32  passed-frame counter

Behaviour:
- Reset (wb_rst_i=0, async): state DROP; params = INIT_*; shadows = INIT_*; run = INIT_CTL_RUN; oneshot = 0; upd_req = 0; frame_count = 0; s_wb_dat_o = 0.
- Wishbone: s_wb_ack_o = s_wb_stb_i (combinational, zero wait). Write occurs on stb&we at posedge, byte-masked by sel. Read data is combinational from address.
- Register map (word address):
  - 0x00 ID RO 0x4D53_4643.
  - 0x01 CONTROL: bit0 upd_req (W1 sets; self-clears when applied), bit1 run, bit2 oneshot (W1 sets; self-clears when its frame starts), bit3 upd_now (W1: immediate copy; reads 0).
  - 0x02 STATUS RO: bit0 state (1 = PASS), bit1 upd_req, bit2 oneshot.
  - 0x03 FRAME_COUNT RO.
  - 0x08–0x0B shadow TH / INV / COLOR_MODE / COLOR_TH, RW.
  - 0x18–0x1B active values, RO.
  - Unmapped addresses read 0; writes to them are ignored.
- sof = s_axi4s_tvalid & s_axi4s_tuser[0]. start = run | oneshot.
- Gate: pass_sel = sof ? start : (state==PASS).
  - m_axi4s_tvalid = s_axi4s_tvalid & pass_sel.
  - s_axi4s_tready = pass_sel ? m_axi4s_tready : 1 (drop = consume).
  - Beat accepted = s_axi4s_tvalid & s_axi4s_tready.
- FSM (evaluated on accepted SOF beat only):
  - start=1 → PASS; frame_count += 1 (wraps at 2^32-1 → 0); oneshot cleared.
  - start=0 → DROP.
  - Non-SOF beats never change state. tlast has no effect on state.
  - Clearing run mid-frame lets the current frame finish; the stop takes effect at the next SOF.
- Parameter transfer: on every accepted SOF beat with upd_req=1, copy shadows → active and clear upd_req, same cycle as the FSM decision (dropped SOFs included). upd_now copies on the write cycle regardless of stream state.
- Simultaneous events:
  - SOF clear and a WB write setting upd_req/oneshot in the same cycle: the write wins (bit stays set).
  - A shadow write in the same cycle as a copy: the copy uses the old shadow value.
- Backpressure: when m_axi4s_tready=0 on an SOF beat, nothing changes until that beat is accepted.
- Latency: purely combinational handshake path; registered state/params take effect the cycle after acceptance.

Test Plan:
- Reset, read 0x00/0x18 → 0x4D534643, 127; stream with run=0 → m_axi4s_tvalid never 1, s_axi4s_tready=1, frame_count=0.
- Write run=1 mid-frame, feed 3 frames of 160x120 → passing starts at next SOF; exactly 3 frames pass; frame_count=3.
- oneshot=1 with run=0 over 3 frames → exactly one frame passed; STATUS.bit2 clears at its SOF; frame_count=1.
- Write TH=0x40, upd_req=1 mid-frame → param_th stays 127 until next accepted SOF, then 0x40; upd_req reads 0 afterward.
- Clear run mid-frame with m_axi4s_tready toggling randomly → current frame completes without lost beats; next frame dropped; SOF beat held under ready=0 does not advance frame_count.
- Assert wb_rst_i low mid-frame → all outputs return to INIT values immediately; after release, stream is dropped until the next SOF with run=1.
